// File: rtl/hs_mon_pkg.sv
// Shared types and helpers for the valid/ready handshake monitor.
// The HS_MONITOR_FORMAL_EN macro (see hs_mon_channel) adds per-channel concurrent properties.
package hs_mon_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ch_state_e;

    // Counter must reach MAX_WAIT+1 so a saturated stall never re-matches MAX_WAIT.
    function automatic int wait_cnt_width(input int max_wait);
        return $clog2(max_wait + 2);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] base,
                                            input logic [31:0] inc,
                                            input int          width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, base} + {1'b0, inc};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/hs_mon_channel.sv
// Single-channel handshake tracker: IDLE/WAIT FSM, held payload, wait counter, event strobes.
// Defining HS_MONITOR_FORMAL_EN adds concurrent properties on this channel.
module hs_mon_channel
    import hs_mon_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
`ifdef HS_MONITOR_FORMAL_EN
    ,
    parameter int CH_IDX   = 0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic              ev_stable,
    output logic              ev_drop,
    output logic              ev_timeout,
    output logic              busy
);

    localparam int WCW = wait_cnt_width(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT + 1);

    ch_state_e         state_q, state_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        wait_cnt_d = wait_cnt_q;
        ev_stable  = 1'b0;
        ev_drop    = 1'b0;
        ev_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid && !ready) begin
                    state_d    = ST_WAIT;
                    held_d     = data;
                    wait_cnt_d = WCW'(1);
                end
            end
            ST_WAIT: begin
                // Payload is compared even on the accepting cycle.
                ev_stable = valid && (data != held_q);
                if (!valid) begin
                    ev_drop    = 1'b1;
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (ready) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    ev_timeout = (wait_cnt_q == WAIT_MAX);
                    if (wait_cnt_q != WAIT_SAT) begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            held_q     <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign busy = (state_q == ST_WAIT);

`ifdef HS_MONITOR_FORMAL_EN
    p_valid_hold: assert property (@(posedge clk) disable iff (rst)
        (valid && !ready) |=> valid)
        else $error("ch%0d: valid dropped while stalled", CH_IDX);

    p_data_stable: assert property (@(posedge clk) disable iff (rst)
        (valid && !ready) |=> $stable(data))
        else $error("ch%0d: data changed while stalled", CH_IDX);

    p_max_stall: assert property (@(posedge clk) disable iff (rst)
        !((state_q == ST_WAIT) && valid && !ready && (wait_cnt_q >= WAIT_MAX)))
        else $error("ch%0d: stall exceeded MAX_WAIT", CH_IDX);

    c_stalled_handshake: cover property (@(posedge clk) disable iff (rst)
        (valid && !ready) [*2:$] ##1 (valid && ready));
`endif

endmodule

// File: rtl/hs_protocol_monitor.sv
// Multi-channel valid/ready protocol monitor: sticky per-channel error flags plus a
// saturating violation counter. HS_MONITOR_FORMAL_EN enables per-channel properties.
module hs_protocol_monitor
    import hs_mon_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [NUM_CH-1:0]        ready,
    input  logic [NUM_CH*DATA_W-1:0] data,
    input  logic                     clear,
    output logic [NUM_CH-1:0]        err_stable,
    output logic [NUM_CH-1:0]        err_drop,
    output logic [NUM_CH-1:0]        err_timeout,
    output logic [CNT_W-1:0]         viol_count,
    output logic [NUM_CH-1:0]        busy
);

    logic [NUM_CH-1:0] ev_stable, ev_drop, ev_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            hs_mon_channel #(
                .DATA_W   (DATA_W),
                .MAX_WAIT (MAX_WAIT)
`ifdef HS_MONITOR_FORMAL_EN
                ,
                .CH_IDX   (gi)
`endif
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .valid      (valid[gi]),
                .ready      (ready[gi]),
                .data       (data[gi*DATA_W +: DATA_W]),
                .ev_stable  (ev_stable[gi]),
                .ev_drop    (ev_drop[gi]),
                .ev_timeout (ev_timeout[gi]),
                .busy       (busy[gi])
            );
        end
    endgenerate

    logic [NUM_CH-1:0] err_stable_q, err_stable_d;
    logic [NUM_CH-1:0] err_drop_q, err_drop_d;
    logic [NUM_CH-1:0] err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]  viol_count_q, viol_count_d;
    logic [CNT_W-1:0]  cnt_base;
    logic [31:0]       ev_total;

    // clear wipes history, but events of the clearing cycle land on the fresh value.
    always_comb begin
        ev_total      = 32'($countones({ev_stable, ev_drop, ev_timeout}));
        err_stable_d  = (clear ? '0 : err_stable_q)  | ev_stable;
        err_drop_d    = (clear ? '0 : err_drop_q)    | ev_drop;
        err_timeout_d = (clear ? '0 : err_timeout_q) | ev_timeout;
        cnt_base      = clear ? '0 : viol_count_q;
        viol_count_d  = CNT_W'(sat_add(32'(cnt_base), ev_total, CNT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_stable_q  <= '0;
            err_drop_q    <= '0;
            err_timeout_q <= '0;
            viol_count_q  <= '0;
        end else begin
            err_stable_q  <= err_stable_d;
            err_drop_q    <= err_drop_d;
            err_timeout_q <= err_timeout_d;
            viol_count_q  <= viol_count_d;
        end
    end

    assign err_stable  = err_stable_q;
    assign err_drop    = err_drop_q;
    assign err_timeout = err_timeout_q;
    assign viol_count  = viol_count_q;

endmodule

// File: doc/hs_protocol_monitor.md
Name: hs_protocol_monitor

Overview:
- Multi-channel valid/ready handshake protocol checker; the parametrised successor to single-property concurrent checks.
- Watches NUM_CH independent channels for three violations: data instability while stalled, valid dropped before acceptance, and bounded-wait timeout.
- Reports sticky per-channel error flags and a saturating global violation counter.
- Sits beside any valid/ready interface as a passive, synthesizable monitor; it can also carry formal properties.

Parameters:
- NUM_CH, 4, number of monitored channels (>=1)
- DATA_W, 8, payload width per channel
- MAX_WAIT, 15, maximum stall cycles tolerated before a timeout (>=1)
- CNT_W, 8, width of the saturating violation counter

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- valid  input  NUM_CH  per-channel valid
- ready  input  NUM_CH  per-channel ready
- data  input  NUM_CH*DATA_W  payloads; channel i occupies bits [i*DATA_W +: DATA_W]
- clear  input  1  synchronous clear of sticky flags and counter
- err_stable  output  NUM_CH  sticky: payload changed while stalled
- err_drop  output  NUM_CH  sticky: valid deasserted while stalled
- err_timeout  output  NUM_CH  sticky: stall exceeded MAX_WAIT
- viol_count  output  CNT_W  total violation events, saturating
- busy  output  NUM_CH  channel currently in WAIT

Behaviour:
- Reset: all outputs 0, every channel in IDLE, wait counters 0, held payloads 0. Reset mid-stall abandons the stall without flagging any error.
- Per-channel FSM states: IDLE and WAIT.
  - IDLE, valid&&!ready: go to WAIT, capture data into the held register, wait_cnt=1.
  - IDLE, valid&&ready: transfer; stay in IDLE.
  - IDLE, !valid: stay in IDLE.
  - WAIT, valid&&ready: transfer; go to IDLE, wait_cnt=0. Data mismatch in this cycle is still checked.
  - WAIT, !valid: drop event; go to IDLE.
  - WAIT, valid&&!ready: stay in WAIT; wait_cnt increments, saturating at MAX_WAIT+1.
- Stable event: in WAIT with valid high, data != held payload. Flagged on every such cycle; the held payload is not updated.
- Timeout event: in WAIT with valid&&!ready while wait_cnt==MAX_WAIT. Fires exactly once per stall and never re-fires while saturated.
- Flags: each event sets its sticky flag in the next cycle (1-cycle registered latency).
- busy = (state==WAIT), registered.
- viol_count adds the popcount of all events (3*NUM_CH sources) each cycle, clamped to 2^CNT_W-1 with no wrap.
- clear: zeros all flags and viol_count. Events in the same cycle are still recorded on top of the cleared value, so a same-cycle event is never lost. clear does not affect FSM state.
- rst has priority over clear.

Optional Feature:
- Macro HS_MONITOR_FORMAL_EN.
- Defined: the per-channel generate block additionally emits concurrent properties, all under @(posedge clk) disable iff (rst):
  - assert valid&&!ready |=> valid
  - assert valid&&!ready |=> $stable(data slice)
  - assert no stall longer than MAX_WAIT
  - cover a handshake completing after a stall of at least 2 cycles
  - Every property carries a label with the channel index.
- Undefined: no property statements are emitted; the RTL checker alone.
- Output behaviour is identical either way.

Decomposition:
- Package hs_mon_pkg holds:
  - the state enum (ST_IDLE, ST_WAIT)
  - a wait-counter width function clog2(MAX_WAIT+2)
  - a saturating-add function for the counter
- Sub-module hs_mon_channel owns the FSM, held payload, wait counter, event outputs and the optional properties. It is instantiated NUM_CH times.
- The top level owns the sticky flags, popcount and viol_count.

Test Plan:
- Ch0: valid=1, ready=0 with data=0x3C for 3 cycles, then ready=1. Required: busy[0]=1 for 3 cycles, no flags, viol_count=0.
- Ch1: stall with data=0x11, data changes to 0x12 on the 2nd stall cycle. Required: err_stable[1]=1 the next cycle, viol_count=1.
- Ch2: stall 2 cycles, then valid=0. Required: err_drop[2]=1, ch2 returns to IDLE.
- Ch3: stall 20 cycles with MAX_WAIT=15. Required: err_timeout[3] rises once, viol_count increments by exactly 1.
- Simultaneous events: drop on ch0 and stable on ch1 in the same cycle as clear. Required: both flags set, viol_count=2.
- CNT_W=2 with 5 violation events. Required: viol_count holds at 3.
- Reset asserted mid-stall. Required: all outputs 0 the next cycle, no flag set.
